fifo2: RTL and testbench
========================

# fifo2

Parametrised single-clock synchronous FIFO, the next generation of the team's 64×14 buffer. It adds a selectable read mode (registered or first-word fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and buffers samples across rate mismatches and bursts.

## Interface
- WIDTH, 14, data word width in bits (≥1)
- DEPTH, 64, storage words; power of two, ≥4
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = registered read, 1 = first-word fall-through
- AW (local), log2(DEPTH), pointer width

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush; emptied, error flags kept
- din  in  WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (FWFT: acknowledge of head word)
- dout  out  WIDTH  read data
- valid  out  1  dout holds a freshly read word (FWFT: head word present)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  AW+1  stored words, 0..DEPTH
- overflow  out  1  sticky; a write was rejected
- underflow  out  1  sticky; a read was rejected

## Operation
- Storage: DEPTH×WIDTH array. Write pointer wp and read pointer rp are AW bits and wrap modulo DEPTH. count is a separate AW+1-bit register.
- Write accepted iff wr_en && !full. The word is stored at wp and wp increments.
- Read accepted iff rd_en && !empty. rp increments.
- A full FIFO rejects a write even if a read happens in the same cycle. An empty FIFO rejects a read even if a write happens in the same cycle. There is no bypass.
- count update: +1 on an accepted write only, −1 on an accepted read only, unchanged when both or neither are accepted.
- The flags (empty, full, almost_*) are decoded combinationally from the count register, so they change in the cycle after the accepted operation.
- overflow is set by wr_en && full; underflow is set by rd_en && empty. Both hold until rst; clr does not clear them.
- FWFT=0:
  - On an accepted read, dout is loaded from ram[rp] and valid=1 the next cycle.
  - Otherwise valid=0 and dout holds its last value.
- FWFT=1:
  - dout = ram[rp] combinationally and valid = !empty.
  - rd_en pops the head word; the next word appears the following cycle.
- clr:
  - wp, rp and count go to 0 and valid goes to 0; in FWFT=0, dout goes to 0.
  - wr_en and rd_en in the same cycle are ignored, and do not set the error flags.
- Priority: rst > clr > normal operation.

## Timing
- Reset values: dout=0, valid=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0, wp=rp=0. Memory contents are not reset.
- Reset mid-operation discards all stored data. The first write after rst deasserts is accepted in the cycle rst is low.
- Write-to-read latency:
  - FWFT=0: a write at cycle n clears empty at n+1; a read at n+1 gives valid dout at n+2.
  - FWFT=1: a write at cycle n gives valid=1 with dout=din at n+1.
- Sustained throughput is one write and one read per cycle at any count strictly between 0 and DEPTH.
- Pointer wrap from DEPTH-1 to 0 must be seamless; count alone disambiguates full from empty.

## Test plan
- Reset then fill: rst for 2 cycles, then write 0..63 (DEPTH=64) on consecutive cycles.
  - After reset: empty=1, count=0.
  - almost_full=1 once count reaches 60.
  - full=1 the cycle after the 64th write; count=64.
  - A 65th write sets overflow=1, and count stays 64.
- Drain FWFT=0: from full, assert rd_en for 64 cycles.
  - dout = 0,1,…,63, each with valid the cycle after its read.
  - almost_empty=1 at count=4; empty=1 after the last read.
  - An extra rd_en sets underflow=1, leaves valid=0, and dout holds 63.
- FWFT=1 fall-through: write 0xABC into an empty FIFO.
  - Next cycle: valid=1, dout=0xABC.
  - rd_en that cycle: empty=1 and valid=0 the cycle after.
- Simultaneous operations:
  - At count=10, wr_en and rd_en together for 100 cycles: count stays 10, pointers wrap, data order is preserved.
  - At full with both asserted: read accepted, write rejected, count=63, overflow=1.
  - At empty with both asserted: write accepted, count=1, underflow=1.
- Flush: at count=20, pulse clr together with wr_en.
  - Next cycle: count=0, empty=1, valid=0; overflow and underflow unchanged.
  - A subsequent write/read returns the new data.
- Parameter sweep: DEPTH=4, WIDTH=1, AF_LEVEL=3, AE_LEVEL=0. Repeat the fill/drain and random wr_en/rd_en against a reference queue model: count, all flags and data match every cycle.

Source files
------------

// File: rtl/fifo2.sv
// fifo2: single-clock synchronous FIFO with selectable registered or
// first-word fall-through read, occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo2 #(
  parameter int WIDTH    = 14,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the count register so comparisons stay width-matched.
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0] AF_CNT    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_CNT    = AE_LEVEL[AW:0];

  logic [WIDTH-1:0] ram [DEPTH];

  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rp_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  logic wr_ok;
  logic rd_ok;

  // Flags come straight from the count register, so they follow an
  // accepted operation by one cycle. The count alone separates full from
  // empty, which keeps pointer wrap trivial.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign almost_full  = (count_reg >= AF_CNT);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Flush and reset swallow any request issued in the same cycle; there is
  // no write-to-read bypass, so an empty FIFO rejects a read even when a
  // write lands at the same time (and likewise for full).
  assign wr_ok = wr_en && !full  && !clr && !rst;
  assign rd_ok = rd_en && !empty && !clr && !rst;

  // Storage write; memory contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ram[wp_reg] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (wr_ok) begin
        wp_reg <= wp_reg + 1'b1;
      end
      if (rd_ok) begin
        rp_reg <= rp_reg + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky error flags; only reset clears them, a flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (!clr) begin
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_en acknowledges and pops it.
      assign dout  = ram[rp_reg];
      assign valid = !empty;
    end else begin : g_registered
      logic [WIDTH-1:0] dout_reg;
      logic             valid_reg;

      // Registered read: an accepted read loads the head word, valid pulses
      // for one cycle, and dout otherwise holds its last value.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          dout_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= rd_ok;
          if (rd_ok) begin
            dout_reg <= ram[rp_reg];
          end
        end
      end

      assign dout  = dout_reg;
      assign valid = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo2.sv
// tb_fifo2: drives three fifo2 configurations (registered 64x14, FWFT 64x14,
// and a 4x1 corner build) one at a time and compares every cycle against a
// queue-based reference model of the FIFO rules.
module tb_fifo2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  int          sel;

  // Instance 0: 64x14 registered read
  logic [13:0] a_dout;
  logic [6:0]  a_count;
  logic        a_valid, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  // Instance 1: 64x14 first-word fall-through
  logic [13:0] b_dout;
  logic [6:0]  b_count;
  logic        b_valid, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  // Instance 2: 4x1 registered read, AF=3, AE=0
  logic [0:0]  c_dout;
  logic [2:0]  c_count;
  logic        c_valid, c_empty, c_full, c_ae, c_af, c_ovf, c_unf;

  fifo2 #(.WIDTH(14), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(4), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .din(din[13:0]),
    .wr_en(wr_en && sel == 0), .rd_en(rd_en && sel == 0),
    .dout(a_dout), .valid(a_valid), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  fifo2 #(.WIDTH(14), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(4), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .din(din[13:0]),
    .wr_en(wr_en && sel == 1), .rd_en(rd_en && sel == 1),
    .dout(b_dout), .valid(b_valid), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  fifo2 #(.WIDTH(1), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(0), .FWFT(0)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .din(din[0:0]),
    .wr_en(wr_en && sel == 2), .rd_en(rd_en && sel == 2),
    .dout(c_dout), .valid(c_valid), .empty(c_empty), .full(c_full),
    .almost_empty(c_ae), .almost_full(c_af), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf)
  );

  // Outputs of the instance under test, widened to 32 bits.
  logic [31:0] o_dout, o_count;
  logic        o_valid, o_empty, o_full, o_ae, o_af, o_ovf, o_unf;

  // Select which instance's outputs are being checked.
  always_comb begin
    o_dout  = '0;
    o_count = '0;
    o_valid = 1'b0;
    o_empty = 1'b0;
    o_full  = 1'b0;
    o_ae    = 1'b0;
    o_af    = 1'b0;
    o_ovf   = 1'b0;
    o_unf   = 1'b0;
    case (sel)
      0: begin
        o_dout = 32'(a_dout); o_count = 32'(a_count); o_valid = a_valid;
        o_empty = a_empty; o_full = a_full; o_ae = a_ae; o_af = a_af;
        o_ovf = a_ovf; o_unf = a_unf;
      end
      1: begin
        o_dout = 32'(b_dout); o_count = 32'(b_count); o_valid = b_valid;
        o_empty = b_empty; o_full = b_full; o_ae = b_ae; o_af = b_af;
        o_ovf = b_ovf; o_unf = b_unf;
      end
      default: begin
        o_dout = 32'(c_dout); o_count = 32'(c_count); o_valid = c_valid;
        o_empty = c_empty; o_full = c_full; o_ae = c_ae; o_af = c_af;
        o_ovf = c_ovf; o_unf = c_unf;
      end
    endcase
  end

  // Reference model: contents as a queue plus the observable side state.
  logic [31:0] mq [$];
  int          m_depth;
  int          m_af;
  int          m_ae;
  int          m_fwft;
  logic [31:0] m_mask;
  logic        m_ovf;
  logic        m_unf;
  logic        m_valid;
  logic [31:0] m_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (inst %0d cycle %0d)", tag, got, exp, sel, n_cyc);
    end
  endtask

  // One clock: apply the request, advance the model, compare everything.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [31:0] d);
    logic [31:0] h;
    bit          wa;
    bit          ra;
    int          sz;
    wr_en = w;
    rd_en = r;
    clr   = c;
    din   = d;
    @(posedge clk);
    #1;
    n_cyc++;
    wa = 1'b0;
    ra = 1'b0;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_valid = 1'b0;
    end else if (c) begin
      mq.delete();
      m_dout = '0; m_valid = 1'b0;
    end else begin
      wa = w && (mq.size() < m_depth);
      ra = r && (mq.size() > 0);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_unf = 1'b1;
      m_valid = 1'b0;
      if (ra) begin
        h = mq.pop_front();
        m_valid = 1'b1;
        m_dout = h;
      end
      if (wa) mq.push_back(d & m_mask);
    end
    sz = mq.size();
    check("count",        o_count,       32'(sz));
    check("empty",        32'(o_empty),  32'(sz == 0));
    check("full",         32'(o_full),   32'(sz == m_depth));
    check("almost_empty", 32'(o_ae),     32'(sz <= m_ae));
    check("almost_full",  32'(o_af),     32'(sz >= m_af));
    check("overflow",     32'(o_ovf),    32'(m_ovf));
    check("underflow",    32'(o_unf),    32'(m_unf));
    if (m_fwft != 0) begin
      check("valid", 32'(o_valid), 32'(sz != 0));
      if (sz != 0) check("dout", o_dout, mq[0]);
    end else begin
      check("valid", 32'(o_valid), 32'(m_valid));
      check("dout",  o_dout,       m_dout);
    end
    $display("inst %0d cyc %0d rst=%0b clr=%0b wr=%0b(%0b) rd=%0b(%0b) din=%0h count=%0d dout=%0h valid=%0b",
             sel, n_cyc, rst, c, w, wa, r, ra, d & m_mask, o_count, o_dout, o_valid);
  endtask

  task automatic run_inst(input int s, input int depth, input logic [31:0] mask,
                          input int af, input int ae, input int fwft);
    int k;
    sel = s; m_depth = depth; m_mask = mask; m_af = af; m_ae = ae; m_fwft = fwft;
    // reset for two cycles
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    rst = 1'b0;
    // fill with 0..DEPTH-1, then one rejected write
    for (int i = 0; i < depth; i++) cyc(1, 0, 0, 32'(i));
    cyc(1, 0, 0, 32'h55);
    // drain everything, then one rejected read
    for (int i = 0; i < depth; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // sustained simultaneous read/write at a mid-level occupancy
    k = (depth > 10) ? 10 : 2;
    for (int i = 0; i < k; i++) cyc(1, 0, 0, $urandom);
    repeat (100) cyc(1, 1, 0, $urandom);
    for (int i = 0; i < k; i++) cyc(0, 1, 0, 0);
    // both requests at full, then at empty
    for (int i = 0; i < depth; i++) cyc(1, 0, 0, $urandom);
    cyc(1, 1, 0, $urandom);
    cyc(1, 0, 0, $urandom);
    for (int i = 0; i < depth; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, $urandom);
    cyc(0, 1, 0, 0);
    // flush with a concurrent write, then fresh data through an empty FIFO
    k = (depth > 20) ? 20 : depth - 1;
    for (int i = 0; i < k; i++) cyc(1, 0, 0, $urandom);
    cyc(1, 1, 1, $urandom);
    cyc(1, 0, 0, 32'hABC);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // random traffic with occasional flush and reset
    repeat (500) begin
      rst = ($urandom_range(0, 299) == 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0), $urandom);
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0; sel = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
    m_depth = 64; m_af = 60; m_ae = 4; m_fwft = 0; m_mask = 32'h3FFF;
    run_inst(0, 64, 32'h3FFF, 60, 4, 0);
    run_inst(1, 64, 32'h3FFF, 60, 4, 1);
    run_inst(2, 4,  32'h1,    3,  0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
